// File: rtl/multi_flex_counter_pkg.sv
// Shared types and constants for the multi-channel flex counter bank.
package multi_flex_counter_pkg;

    localparam int unsigned DEF_CNT_BITS = 4;

    typedef logic [DEF_CNT_BITS-1:0] cnt_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP    = 1'b0,
        MODE_ONESHOT = 1'b1
    } mode_e;

    localparam cnt_t CNT_ZERO = cnt_t'(0);
    localparam cnt_t CNT_ONE  = cnt_t'(1);

endpackage

// File: rtl/multi_flex_counter_ch.sv
// One counter channel: clear > load > step > hold, registered count, level
// flag and single-cycle pulse. step_hit reports a step landing on the
// terminal value this cycle so a neighbouring channel can chain off it.
module flex_counter_ch
    import multi_flex_counter_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         count_enable,
    input  logic         count_down,
    input  logic         one_shot,
    input  logic [W-1:0] rollover_val,
    output logic [W-1:0] count_out,
    output logic         rollover_flag,
    output logic         rollover_pulse,
    output logic         step_hit
);

    localparam logic [W-1:0] ZERO = W'(CNT_ZERO);
    localparam logic [W-1:0] ONE  = W'(CNT_ONE);

    dir_e         dir;
    mode_e        mode;
    logic [W-1:0] terminal;
    logic [W-1:0] step_val;
    logic         step_ok;
    logic [W-1:0] count_nxt;
    logic         flag_nxt;
    logic         pulse_nxt;

    // Decode direction/mode, terminal value and the value a step would produce.
    always_comb begin
        dir      = count_down ? DIR_DOWN : DIR_UP;
        mode     = one_shot ? MODE_ONESHOT : MODE_WRAP;
        terminal = (dir == DIR_DOWN) ? ONE : rollover_val;
        step_val = count_out;
        if (rollover_val == ZERO) begin
            // Degenerate range: steps pin the count at zero.
            step_val = ZERO;
        end else if (dir == DIR_UP) begin
            step_val = (count_out >= rollover_val) ? ONE : count_out + ONE;
        end else begin
            step_val = (count_out <= ONE) ? rollover_val : count_out - ONE;
        end
        // A one-shot channel parked on its terminal ignores further steps.
        step_ok  = count_enable && !clear && !load &&
                   !((mode == MODE_ONESHOT) && rollover_flag);
        step_hit = step_ok && (rollover_val != ZERO) && (step_val == terminal);
    end

    // Next-state selection by priority: clear, load, step, hold.
    always_comb begin
        count_nxt = count_out;
        flag_nxt  = rollover_flag;
        pulse_nxt = 1'b0;
        if (clear) begin
            count_nxt = ZERO;
            flag_nxt  = 1'b0;
        end else if (load) begin
            count_nxt = load_val;
            flag_nxt  = (load_val == terminal);
        end else if (step_ok) begin
            count_nxt = step_val;
            flag_nxt  = step_hit;
            pulse_nxt = step_hit;
        end
    end

    // Channel state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out      <= ZERO;
            rollover_flag  <= 1'b0;
            rollover_pulse <= 1'b0;
        end else begin
            count_out      <= count_nxt;
            rollover_flag  <= flag_nxt;
            rollover_pulse <= pulse_nxt;
        end
    end

endmodule

// File: rtl/multi_flex_counter.sv
// Bank of NUM_CH independent flex counters with packed per-channel buses.
// Optional macro MULTI_FLEX_COUNTER_CASCADE_EN: channel i (i > 0) steps only
// when its own enable is high and channel i-1 steps onto its terminal in the
// same cycle (combinational ripple, whole chain advances in one clock).
module multi_flex_counter
    import multi_flex_counter_pkg::*;
#(
    parameter int unsigned NUM_CNT_BITS = 4,
    parameter int unsigned NUM_CH       = 4
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic [NUM_CH-1:0]              clear,
    input  logic [NUM_CH-1:0]              load,
    input  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val,
    input  logic [NUM_CH-1:0]              count_enable,
    input  logic [NUM_CH-1:0]              count_down,
    input  logic [NUM_CH-1:0]              one_shot,
    input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
    output logic [NUM_CH-1:0]              rollover_flag,
    output logic [NUM_CH-1:0]              rollover_pulse
);

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            logic en_eff;
            logic hit;
            logic unused_hit;

            if (i == 0) begin : g_first
                assign en_eff = count_enable[i];
            end else begin : g_rest
`ifdef MULTI_FLEX_COUNTER_CASCADE_EN
                assign en_eff = count_enable[i] & g_ch[i-1].hit;
`else
                assign en_eff = count_enable[i];
`endif
            end

            // The last channel's hit (and every hit when not chaining) has no consumer.
            assign unused_hit = hit;

            flex_counter_ch #(
                .W(NUM_CNT_BITS)
            ) u_ch (
                .clk           (clk),
                .n_rst         (n_rst),
                .clear         (clear[i]),
                .load          (load[i]),
                .load_val      (load_val[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
                .count_enable  (en_eff),
                .count_down    (count_down[i]),
                .one_shot      (one_shot[i]),
                .rollover_val  (rollover_val[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
                .count_out     (count_out[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
                .rollover_flag (rollover_flag[i]),
                .rollover_pulse(rollover_pulse[i]),
                .step_hit      (hit)
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_flex_counter.sv
// Directed bench for multi_flex_counter (W = 4, NUM_CH = 4) with an
// expected-value queue drained after every clock.
module tb_multi_flex_counter;

    localparam int unsigned W  = 4;
    localparam int unsigned NC = 4;

    logic              clk;
    logic              n_rst;
    logic [NC-1:0]     clear;
    logic [NC-1:0]     load;
    logic [NC*W-1:0]   load_val;
    logic [NC-1:0]     count_enable;
    logic [NC-1:0]     count_down;
    logic [NC-1:0]     one_shot;
    logic [NC*W-1:0]   rollover_val;
    logic [NC*W-1:0]   count_out;
    logic [NC-1:0]     rollover_flag;
    logic [NC-1:0]     rollover_pulse;

    // entry = {channel[1:0], count[3:0], flag, pulse}
    logic [7:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    multi_flex_counter #(
        .NUM_CNT_BITS(W),
        .NUM_CH      (NC)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (clear),
        .load          (load),
        .load_val      (load_val),
        .count_enable  (count_enable),
        .count_down    (count_down),
        .one_shot      (one_shot),
        .rollover_val  (rollover_val),
        .count_out     (count_out),
        .rollover_flag (rollover_flag),
        .rollover_pulse(rollover_pulse)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input int ch, input logic [3:0] c, input logic f, input logic p);
        exp_q.push_back({2'(ch), c, f, p});
    endtask

    task automatic push_all_zero();
        for (int c = 0; c < int'(NC); c++) push_exp(c, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic drain(input string step);
        logic [7:0] e;
        int ch;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            ch = int'(e[7:6]);
            check($sformatf("%s_ch%0d_count", step, ch), 8'(count_out[ch*W +: W]), 8'(e[5:2]));
            check($sformatf("%s_ch%0d_flag", step, ch), 8'(rollover_flag[ch]), 8'(e[1]));
            check($sformatf("%s_ch%0d_pulse", step, ch), 8'(rollover_pulse[ch]), 8'(e[0]));
        end
    endtask

    // advance one clock, then compare at the falling edge
    task automatic tick(input string step);
        @(posedge clk);
        @(negedge clk);
        drain(step);
    endtask

    initial begin
        logic [3:0] c0;
        logic [3:0] c1;
        int adv;

        n_rst        = 1'b0;
        clear        = '0;
        load         = '0;
        load_val     = '0;
        count_enable = '0;
        count_down   = '0;
        one_shot     = '0;
        rollover_val = '0;

        // reset held for three clocks
        for (int k = 0; k < 3; k++) begin
            push_all_zero();
            tick("reset_hold");
        end
        n_rst = 1'b1;
        push_all_zero();
        tick("reset_release");

        // ch0: up, wrap, rollover 5
        rollover_val[0*W +: W] = 4'd5;
        count_enable[0] = 1'b1;
        begin
            logic [3:0] seq0 [7];
            seq0 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1, 4'd2};
            for (int k = 0; k < 7; k++) begin
                push_exp(0, seq0[k], seq0[k] == 4'd5, seq0[k] == 4'd5);
                tick("ch0_up");
            end
        end
        count_enable[0] = 1'b0;
        push_exp(0, 4'd2, 1'b0, 1'b0);
        tick("ch0_hold");

`ifndef MULTI_FLEX_COUNTER_CASCADE_EN
        // ch1: down, one-shot, load 3 then five steps
        rollover_val[1*W +: W] = 4'd6;
        count_down[1] = 1'b1;
        one_shot[1]   = 1'b1;
        load[1]       = 1'b1;
        load_val[1*W +: W] = 4'd3;
        push_exp(1, 4'd3, 1'b0, 1'b0);
        tick("ch1_load");
        load[1] = 1'b0;
        count_enable[1] = 1'b1;
        push_exp(1, 4'd2, 1'b0, 1'b0);
        tick("ch1_dn0");
        push_exp(1, 4'd1, 1'b1, 1'b1);
        tick("ch1_dn1");
        for (int k = 0; k < 3; k++) begin
            push_exp(1, 4'd1, 1'b1, 1'b0);
            tick("ch1_stuck");
        end
        count_enable[1] = 1'b0;
        clear[1] = 1'b1;
        push_exp(1, 4'd0, 1'b0, 1'b0);
        tick("ch1_clear");
        clear[1] = 1'b0;

        // ch2: clear beats load beats step
        rollover_val[2*W +: W] = 4'd5;
        clear[2] = 1'b1;
        load[2]  = 1'b1;
        count_enable[2] = 1'b1;
        load_val[2*W +: W] = 4'd9;
        push_exp(2, 4'd0, 1'b0, 1'b0);
        tick("ch2_prio");
        clear[2] = 1'b0;
        count_enable[2] = 1'b0;
        push_exp(2, 4'd9, 1'b0, 1'b0);
        tick("ch2_load9");
        load[2] = 1'b0;
        count_enable[2] = 1'b1;
        push_exp(2, 4'd1, 1'b0, 1'b0);
        tick("ch2_wrap");
        count_enable[2] = 1'b0;

        // ch3: degenerate rollover 0, then rollover 1
        rollover_val[3*W +: W] = 4'd0;
        count_enable[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push_exp(3, 4'd0, 1'b0, 1'b0);
            tick("ch3_rv0");
        end
        rollover_val[3*W +: W] = 4'd1;
        for (int k = 0; k < 3; k++) begin
            push_exp(3, 4'd1, 1'b1, 1'b1);
            tick("ch3_rv1");
        end
        count_enable[3] = 1'b0;
        push_exp(3, 4'd1, 1'b1, 1'b0);
        tick("ch3_hold");
`endif

        // asynchronous reset with ch0 at 3
        count_enable[0] = 1'b1;
        push_exp(0, 4'd3, 1'b0, 1'b0);
        tick("ch0_to3");
        count_enable[0] = 1'b0;
        #2;
        n_rst = 1'b0;
        #1;
        push_all_zero();
        drain("async_rst");
        @(negedge clk);
        n_rst = 1'b1;
        clear = '0;
        load  = '0;
        push_all_zero();
        tick("async_release");

`ifdef MULTI_FLEX_COUNTER_CASCADE_EN
        // cascade: ch0 rollover 3 prescales ch1 rollover 2
        count_down   = '0;
        one_shot     = '0;
        rollover_val = '0;
        rollover_val[0*W +: W] = 4'd3;
        rollover_val[1*W +: W] = 4'd2;
        count_enable = '1;
        for (int k = 1; k <= 12; k++) begin
            c0  = 4'((k - 1) % 3 + 1);
            adv = k / 3;
            c1  = (adv == 0) ? 4'd0 : 4'((adv - 1) % 2 + 1);
            push_exp(0, c0, c0 == 4'd3, c0 == 4'd3);
            push_exp(1, c1, c1 == 4'd2, (k % 6) == 0);
            tick($sformatf("cascade_c%0d", k));
        end
        count_enable = '0;
`else
        c0  = 4'd0;
        c1  = 4'd0;
        adv = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
